alu_seq_unit: RTL and testbench
===============================

// Module: alu_seq_unit
// PURPOSE
//  Parametrised, registered, multi-cycle successor to the 4-bit combinational ALU.
//  Latches operands on a start/ready handshake and executes one of 8 ops.
//  Returns result plus flags with a one-cycle done pulse.
//  Sits between operand entry (CreateNumber/debounced buttons) and DisplayNumber/SSeg_Dev.
// PARAMETERS
//  W       4   operand/result width (>=2)
//  MUL_EN  1   1: op 7 = iterative shift-add multiply; 0: op 7 gives res=0, single-cycle
// PORTS
//  clk     in   1   system clock, all state on posedge
//  rst     in   1   asynchronous, active-high reset
//  start   in   1   request; accepted when start&ready on a clk edge
//  op      in   3   0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT(signed), 6 SHL, 7 MUL
//  a       in   W   operand A
//  b       in   W   operand B (shift amount for SHL)
//  ready   out  1   high only in IDLE
//  busy    out  1   high in EXEC/MUL/DONE
//  done    out  1   one-cycle pulse: res/flags just updated
//  res     out  W   result (low W bits for MUL)
//  res_hi  out  W   MUL upper W bits; 0 for all other ops
//  cout    out  1   ADD carry; SUB no-borrow (A+~B+1); MUL |res_hi; else 0
//  ovf     out  1   signed overflow for ADD/SUB; else 0
//  zero    out  1   res=={W{1'b0}}
//  neg     out  1   res[W-1]
// BEHAVIOUR
//  - Reset (async, any time, incl. mid-MUL): state IDLE, ready=1, all other outputs 0; op aborted.
//  - FSM IDLE->EXEC on accept (ops 0-6, or op 7 with MUL_EN=0); IDLE->MUL on accept of op 7 with MUL_EN=1.
//    EXEC->DONE; MUL->DONE after W iterations; DONE->IDLE unconditionally.
//  - Operand/op latch at accept edge k; a/b/op changes while busy have no effect.
//  - Latency: simple ops register result at edge k+1 (done=1 in cycle after k+1).
//    MUL: iterations at edges k+1..k+W, result at edge k+W+1.
//  - start while ready=0 is ignored, not queued. Throughput: one simple op per 3 cycles.
//  - res/flags are held stable from one done to the next; they change only at the result edge.
//  - Arithmetic is mod 2^W.
//    SUB = A+~B+1. SLT: res = {{W-1{0}}, $signed(A)<$signed(B)}.
//    SHL: logical, by full B value; B>=W gives res=0.
//  - ovf (ADD) = (A[W-1]==B[W-1]) & (S[W-1]!=A[W-1]); SUB uses ~B in place of B.
//  - MUL: unsigned W x W -> 2W, shift-add, one partial product per cycle, W-bit iteration counter.
// STRUCTURE
//  - alu_seq_defs.vh: op codes (OP_ADD..OP_MUL), FSM state encodings (IDLE, EXEC, MUL, DONE).
//  - Sub-module alu_seq_mul: iterative shift-add multiplier (clk, rst, load, a, b -> prod[2W-1:0], fin).
//  - Combinational op mux and flag logic stay in the top; reuse AddSub4b style add/sub expression.
// TESTING (W=4 unless noted)
//  - ADD a=9, b=8 -> res=1, cout=1, ovf=1, zero=0, neg=0; done exactly 1 cycle after accept edge.
//  - SUB a=3, b=5 -> res=E, cout=0, neg=1, ovf=0; SUB a=5, b=5 -> res=0, zero=1, cout=1.
//  - MUL a=F, b=F -> res=1, res_hi=E, cout=1; done after edge k+5.
//    MUL_EN=0: res=0, done after edge k+1.
//  - SLT a=F, b=1 -> res=1. SHL a=3, b=2 -> res=C. SHL b=5 -> res=0. AND/OR/XOR -> cout=ovf=0.
//  - start held high during MUL with a/b toggling -> single done; result uses the latched operands.
//    Next accept occurs only once ready=1.
//  - rst pulsed at edge k+2 of MUL -> all outputs 0, ready=1 immediately (async), no done pulse.
//    A new ADD afterwards completes normally.

Source files
------------

// File: rtl/alu_seq_unit_pkg.sv
// rtl/alu_seq_unit_pkg.sv - op codes and FSM state encodings for the sequential ALU
package alu_seq_unit_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SLT = 3'd5,
    OP_SHL = 3'd6,
    OP_MUL = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/alu_seq_unit_if.sv
// rtl/alu_seq_unit_if.sv - start/ready request and result/flag bundle of the sequential ALU
interface alu_seq_unit_if #(
  parameter int W = 4
);

  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] res;
  logic [W-1:0] res_hi;
  logic         cout;
  logic         ovf;
  logic         zero;
  logic         neg;

  modport master (
    output start, op, a, b,
    input  ready, busy, done, res, res_hi, cout, ovf, zero, neg
  );

  modport slave (
    input  start, op, a, b,
    output ready, busy, done, res, res_hi, cout, ovf, zero, neg
  );

endinterface

// File: rtl/alu_seq_mul.sv
// rtl/alu_seq_mul.sv - iterative unsigned shift-add multiplier, one partial product per clock
module alu_seq_mul #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] prod,
  output logic           fin
);

  localparam int LAST = W - 1;

  logic [2*W-1:0] mcand_q, mcand_d;
  logic [W-1:0]   mplier_q, mplier_d;
  logic [2*W-1:0] prod_q, prod_d;
  logic [W-1:0]   cnt_q, cnt_d;
  logic           active_q, active_d;
  logic           fin_q, fin_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      fin_q    <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      fin_q    <= fin_d;
    end
  end

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    fin_d    = fin_q;
    if (load) begin
      mcand_d  = {{W{1'b0}}, a};
      mplier_d = b;
      prod_d   = '0;
      cnt_d    = '0;
      active_d = 1'b1;
      fin_d    = 1'b0;
    end else if (active_q) begin
      // Consume multiplier LSB-first while the multiplicand walks left.
      if (mplier_q[0]) begin
        prod_d = prod_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == LAST[W-1:0]) begin
        active_d = 1'b0;
        fin_d    = 1'b1;
      end
    end
  end

  assign prod = prod_q;
  assign fin  = fin_q;

endmodule

// File: rtl/alu_seq_unit.sv
// rtl/alu_seq_unit.sv - registered multi-cycle ALU: latches operands on start&ready, pulses done with result and flags
module alu_seq_unit
  import alu_seq_unit_pkg::*;
#(
  parameter int W      = 4,
  parameter bit MUL_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  alu_seq_unit_if.slave bus
);

  state_e         state_q, state_d;
  op_e            op_q, op_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d;
  logic [W-1:0]   res_q, res_d, res_hi_q, res_hi_d;
  logic           cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d, neg_q, neg_d;

  logic           mul_load;
  logic [2*W-1:0] mul_prod;
  logic           mul_fin;

  logic [W-1:0]   b_eff;
  logic [W:0]     sum;
  logic [W-1:0]   alu_res;
  logic           alu_cout, alu_ovf;

  alu_seq_mul #(.W(W)) u_mul (
    .clk  (clk),
    .rst  (rst),
    .load (mul_load),
    .a    (bus.a),
    .b    (bus.b),
    .prod (mul_prod),
    .fin  (mul_fin)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      res_hi_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      res_hi_q <= res_hi_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
    end
  end

  // Shared adder: SUB is A + ~B + 1, so cout reads as no-borrow.
  always_comb begin
    b_eff    = (op_q == OP_SUB) ? ~b_q : b_q;
    sum      = {1'b0, a_q} + {1'b0, b_eff} + {{W{1'b0}}, (op_q == OP_SUB)};
    alu_res  = '0;
    alu_cout = 1'b0;
    alu_ovf  = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB: begin
        alu_res  = sum[W-1:0];
        alu_cout = sum[W];
        alu_ovf  = (a_q[W-1] == b_eff[W-1]) && (sum[W-1] != a_q[W-1]);
      end
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_SLT: alu_res = {{(W-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      OP_SHL: alu_res = (32'(b_q) >= W) ? '0 : (a_q << b_q);
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    res_hi_d = res_hi_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    mul_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          op_d = op_e'(bus.op);
          a_d  = bus.a;
          b_d  = bus.b;
          if (MUL_EN && (op_e'(bus.op) == OP_MUL)) begin
            mul_load = 1'b1;
            state_d  = ST_MUL;
          end else begin
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        res_d    = alu_res;
        res_hi_d = '0;
        cout_d   = alu_cout;
        ovf_d    = alu_ovf;
        zero_d   = (alu_res == '0);
        neg_d    = alu_res[W-1];
        state_d  = ST_DONE;
      end
      ST_MUL: begin
        if (mul_fin) begin
          res_d    = mul_prod[W-1:0];
          res_hi_d = mul_prod[2*W-1:W];
          cout_d   = |mul_prod[2*W-1:W];
          ovf_d    = 1'b0;
          zero_d   = (mul_prod[W-1:0] == '0);
          neg_d    = mul_prod[W-1];
          state_d  = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.ready  = (state_q == ST_IDLE);
  assign bus.busy   = (state_q != ST_IDLE);
  assign bus.done   = (state_q == ST_DONE);
  assign bus.res    = res_q;
  assign bus.res_hi = res_hi_q;
  assign bus.cout   = cout_q;
  assign bus.ovf    = ovf_q;
  assign bus.zero   = zero_q;
  assign bus.neg    = neg_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// tb/tb_alu_seq_unit.sv - scoreboard bench for alu_seq_unit with MUL_EN=1 and MUL_EN=0 instances
module tb_alu_seq_unit;
  import alu_seq_unit_pkg::*;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_seq_unit_if #(.W(W)) bus ();
  alu_seq_unit_if #(.W(W)) bus0 ();

  alu_seq_unit #(.W(W), .MUL_EN(1'b1)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  alu_seq_unit #(.W(W), .MUL_EN(1'b0)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         cout;
    logic         ovf;
    logic         zero;
    logic         neg;
    int           lat;
    int           k;
  } exp_t;

  exp_t q[$];
  exp_t q0[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.done === 1'b1) begin
      if (q.size() == 0) begin
        chk("m1_unexpected_done", {31'd0, bus.done}, 32'd0);
      end else begin
        e = q.pop_front();
        chk("m1_res", bus.res, e.res);
        chk("m1_res_hi", bus.res_hi, e.hi);
        chk("m1_cout", bus.cout, e.cout);
        chk("m1_ovf", bus.ovf, e.ovf);
        chk("m1_zero", bus.zero, e.zero);
        chk("m1_neg", bus.neg, e.neg);
        chk("m1_latency", cyc - e.k, e.lat);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (bus0.done === 1'b1) begin
      if (q0.size() == 0) begin
        chk("m0_unexpected_done", {31'd0, bus0.done}, 32'd0);
      end else begin
        e = q0.pop_front();
        chk("m0_res", bus0.res, e.res);
        chk("m0_res_hi", bus0.res_hi, e.hi);
        chk("m0_cout", bus0.cout, e.cout);
        chk("m0_ovf", bus0.ovf, e.ovf);
        chk("m0_zero", bus0.zero, e.zero);
        chk("m0_neg", bus0.neg, e.neg);
        chk("m0_latency", cyc - e.k, e.lat);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (bus.ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] res, input logic [W-1:0] hi,
                       input logic cout, input logic ovf, input logic zero, input logic neg,
                       input int lat);
    exp_t e;
    wait_ready();
    chk("issue_ready", {31'd0, bus.ready}, 32'd1);
    if (bus.ready !== 1'b1) return;
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    e = '{res, hi, cout, ovf, zero, neg, lat, cyc};
    q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_ready"}, {31'd0, bus.ready}, 32'd1);
    chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, bus.done}, 32'd0);
    chk({tag, "_res"}, bus.res, 32'd0);
    chk({tag, "_res_hi"}, bus.res_hi, 32'd0);
    chk({tag, "_flags"}, {28'd0, bus.cout, bus.ovf, bus.zero, bus.neg}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   k, k2, n;
    bus.start  = 1'b0; bus.op  = 3'd0; bus.a  = '0; bus.b  = '0;
    bus0.start = 1'b0; bus0.op = 3'd0; bus0.a = '0; bus0.b = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_cleared("reset");
    rst = 1'b0;

    //     op      a      b      res    hi     co ov z  n  lat
    issue(OP_ADD, 4'h9, 4'h8, 4'h1, 4'h0, 1, 1, 0, 0, 1);
    issue(OP_SUB, 4'h3, 4'h5, 4'hE, 4'h0, 0, 0, 0, 1, 1);
    issue(OP_SUB, 4'h5, 4'h5, 4'h0, 4'h0, 1, 0, 1, 0, 1);
    issue(OP_MUL, 4'hF, 4'hF, 4'h1, 4'hE, 1, 0, 0, 0, W + 1);
    issue(OP_SLT, 4'hF, 4'h1, 4'h1, 4'h0, 0, 0, 0, 0, 1);
    issue(OP_SLT, 4'h1, 4'hF, 4'h0, 4'h0, 0, 0, 1, 0, 1);
    issue(OP_SHL, 4'h3, 4'h2, 4'hC, 4'h0, 0, 0, 0, 1, 1);
    issue(OP_SHL, 4'h3, 4'h5, 4'h0, 4'h0, 0, 0, 1, 0, 1);
    issue(OP_AND, 4'hC, 4'hA, 4'h8, 4'h0, 0, 0, 0, 1, 1);
    issue(OP_OR,  4'hC, 4'hA, 4'hE, 4'h0, 0, 0, 0, 1, 1);
    issue(OP_XOR, 4'hC, 4'hA, 4'h6, 4'h0, 0, 0, 0, 0, 1);
    issue(OP_ADD, 4'h7, 4'h1, 4'h8, 4'h0, 0, 1, 0, 1, 1);
    issue(OP_SUB, 4'h8, 4'h1, 4'h7, 4'h0, 1, 1, 0, 0, 1);
    issue(OP_MUL, 4'h3, 4'h5, 4'hF, 4'h0, 0, 0, 0, 1, W + 1);

    // start held through a MUL with operands toggling underneath it
    wait_ready();
    bus.start = 1'b1; bus.op = OP_MUL; bus.a = 4'h3; bus.b = 4'h5;
    @(posedge clk);
    #1;
    k = cyc;
    e = '{4'hF, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, W + 1, k};
    q.push_back(e);
    n = 0;
    @(negedge clk);
    while (bus.ready !== 1'b1 && n < 20) begin
      bus.a  = 4'($urandom);
      bus.b  = 4'($urandom);
      bus.op = 3'($urandom);
      @(negedge clk);
      n++;
    end
    chk("hold_ready", {31'd0, bus.ready}, 32'd1);
    bus.op = OP_ADD; bus.a = 4'h1; bus.b = 4'h2;
    @(posedge clk);
    #1;
    k2 = cyc;
    chk("hold_next_accept", k2 - k, W + 3);
    e = '{4'h3, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1, k2};
    q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;

    // asynchronous reset two edges into a MUL
    wait_ready();
    bus.start = 1'b1; bus.op = OP_MUL; bus.a = 4'hF; bus.b = 4'hF;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk_cleared("async_rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (W + 3) @(negedge clk);
    issue(OP_ADD, 4'h2, 4'h3, 4'h5, 4'h0, 0, 0, 0, 0, 1);

    // MUL_EN=0 instance: op 7 is single-cycle and returns zero
    @(negedge clk);
    bus0.start = 1'b1; bus0.op = OP_MUL; bus0.a = 4'hF; bus0.b = 4'hF;
    @(posedge clk);
    #1;
    e = '{4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1, cyc};
    q0.push_back(e);
    @(negedge clk);
    bus0.start = 1'b0;

    n = 0;
    while ((q.size() != 0 || q0.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    chk("scoreboard_drained", q.size() + q0.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
